// File: rtl/hs_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hs_pkg
// Description : Shared defaults and width helpers for the hs_stream_link slice.
// Revision    : 1.0 - initial release
// ============================================================================
package hs_pkg;

    localparam int DEF_DATA_W = 3;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_CNT_W  = 8;

    // Occupancy must represent 0..DEPTH inclusive, hence DEPTH+1 codes.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage : hs_pkg
`default_nettype wire

// File: rtl/hs_stream_link_if.sv
`default_nettype none
// ============================================================================
// Interface   : hs_stream_link_if
// Description : Control inputs and observation outputs of the stream link.
// Revision    : 1.0 - initial release
// ============================================================================
interface hs_stream_link_if #(
    parameter int DATA_W = hs_pkg::DEF_DATA_W,
    parameter int DEPTH  = hs_pkg::DEF_DEPTH,
    parameter int CNT_W  = hs_pkg::DEF_CNT_W
);
    localparam int LVL_W = hs_pkg::lvl_width(DEPTH);

    logic              src_en;
    logic              ready_in;
    logic [DATA_W-1:0] result;
    logic              result_vld;
    logic [CNT_W-1:0]  xfer_cnt;
    logic [LVL_W-1:0]  fifo_level;
    logic              seq_err;

    modport master (
        output src_en, ready_in,
        input  result, result_vld, xfer_cnt, fifo_level, seq_err
    );

    modport slave (
        input  src_en, ready_in,
        output result, result_vld, xfer_cnt, fifo_level, seq_err
    );

endinterface : hs_stream_link_if
`default_nettype wire

// File: rtl/hs_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hs_fifo
// Description : DEPTH-entry registered elastic FIFO with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_fifo
    import hs_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int LVL_W = lvl_width(DEPTH),
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              in_valid,
    output logic                   in_ready,
    input  wire logic [DATA_W-1:0] in_data,
    output logic                   out_valid,
    input  wire logic              out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [LVL_W-1:0]       level
);

    localparam logic [LVL_W-1:0] C_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] C_EMPTY = '0;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_push;
    logic              w_pop;

    // No write-through: a full FIFO refuses a push even while popping.
    assign in_ready  = (r_level != C_FULL);
    assign out_valid = (r_level != C_EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign out_data  = r_mem[r_rd_ptr];
    assign level     = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : hs_fifo
`default_nettype wire

// File: rtl/hs_stream_link.sv
`default_nettype none
// ============================================================================
// Module      : hs_stream_link
// Description : Counting source -> elastic FIFO -> checking sink, ready_in throttled.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_stream_link
    import hs_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  wire logic         sys_clk,
    input  wire logic         sys_rst,
    hs_stream_link_if.slave   link
);

    localparam int LVL_W = lvl_width(DEPTH);

    logic [DATA_W-1:0] r_src_data;
    logic              r_src_valid;
    logic              w_fifo_in_ready;
    logic              w_fifo_out_valid;
    logic [DATA_W-1:0] w_fifo_data;
    logic [LVL_W-1:0]  w_fifo_level;
    logic              w_beat;
    logic              w_pop;

    logic [DATA_W-1:0] r_result;
    logic              r_result_vld;
    logic [CNT_W-1:0]  r_xfer_cnt;
    logic [DATA_W-1:0] r_expected;
    logic              r_seq_err;

    assign w_beat = r_src_valid && w_fifo_in_ready;
    assign w_pop  = w_fifo_out_valid && link.ready_in;

    // A pending valid is only withdrawn after its beat, regardless of src_en.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_src_data  <= '0;
            r_src_valid <= 1'b0;
        end else if (w_beat) begin
            r_src_data  <= r_src_data + DATA_W'(1);
            r_src_valid <= link.src_en;
        end else if (!r_src_valid) begin
            r_src_valid <= link.src_en;
        end
    end

    hs_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .in_valid  (r_src_valid),
        .in_ready  (w_fifo_in_ready),
        .in_data   (r_src_data),
        .out_valid (w_fifo_out_valid),
        .out_ready (link.ready_in),
        .out_data  (w_fifo_data),
        .level     (w_fifo_level)
    );

    // On a sequence break the expectation re-syncs to the received word.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_result     <= '0;
            r_result_vld <= 1'b0;
            r_xfer_cnt   <= '0;
            r_expected   <= '0;
            r_seq_err    <= 1'b0;
        end else begin
            r_result_vld <= w_pop;
            if (w_pop) begin
                r_result   <= w_fifo_data;
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
                r_expected <= w_fifo_data + DATA_W'(1);
                if (w_fifo_data != r_expected) begin
                    r_seq_err <= 1'b1;
                end
            end
        end
    end

    assign link.result     = r_result;
    assign link.result_vld = r_result_vld;
    assign link.xfer_cnt   = r_xfer_cnt;
    assign link.fifo_level = w_fifo_level;
    assign link.seq_err    = r_seq_err;

endmodule : hs_stream_link
`default_nettype wire

// File: tb/tb_hs_stream_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_stream_link
// Description : Directed self-checking bench for hs_stream_link (DATA_W=3, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_stream_link;

    localparam int C_DATA_W = 3;
    localparam int C_DEPTH  = 4;
    localparam int C_CNT_W  = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   exp_w;
    int   pulses;

    hs_stream_link_if #(.DATA_W(C_DATA_W), .DEPTH(C_DEPTH), .CNT_W(C_CNT_W)) link ();

    hs_stream_link #(
        .DATA_W (C_DATA_W),
        .DEPTH  (C_DEPTH),
        .CNT_W  (C_CNT_W)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .link    (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One cycle with the scoreboard following every sink acceptance.
    task automatic mon();
        tick();
        if (link.result_vld) begin
            chk("result", 32'(link.result), 32'(exp_w));
            exp_w  = (exp_w + 1) % 8;
            pulses = pulses + 1;
            chk("xfer_cnt", 32'(link.xfer_cnt), 32'(pulses % 256));
        end
        chk("level_le_depth", 32'(link.fifo_level <= 3'(C_DEPTH)), 32'd1);
    endtask

    task automatic wait_level(input int lvl);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!hit && (int'(link.fifo_level) == lvl)) hit = 1'b1;
            if (!hit) tick();
        end
        if (!hit) chk("wait_level", 32'(link.fifo_level), 32'(lvl));
    endtask

    task automatic do_reset();
        link.src_en   = 1'b0;
        link.ready_in = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_result", 32'(link.result), 32'd0);
        chk("rst_vld", 32'(link.result_vld), 32'd0);
        chk("rst_cnt", 32'(link.xfer_cnt), 32'd0);
        chk("rst_level", 32'(link.fifo_level), 32'd0);
        chk("rst_seq_err", 32'(link.seq_err), 32'd0);
        rst    = 1'b0;
        exp_w  = 0;
        pulses = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        link.src_en   = 1'b0;
        link.ready_in = 1'b0;

        // 1: free-running stream, first word two cycles after valid rises
        do_reset();
        link.src_en   = 1'b1;
        link.ready_in = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            mon();
            if (k >= 3) chk("t1_vld_cont", 32'(link.result_vld), 32'd1);
        end
        chk("t1_pulses", 32'(pulses), 32'd18);
        chk("t1_seq_err", 32'(link.seq_err), 32'd0);

        // 2: back-pressure fills the FIFO, then drains with no gap
        do_reset();
        link.src_en = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk("t2_level_full", 32'(link.fifo_level), 32'd4);
        chk("t2_src_data", 32'(dut.r_src_data), 32'd4);
        chk("t2_src_valid", 32'(dut.r_src_valid), 32'd1);
        chk("t2_no_vld", 32'(link.result_vld), 32'd0);
        link.ready_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            mon();
            chk("t2_vld_cont", 32'(link.result_vld), 32'd1);
        end
        chk("t2_pulses", 32'(pulses), 32'd12);

        // 3: ready_in toggling every cycle
        do_reset();
        link.src_en = 1'b1;
        for (int k = 0; k < 64; k++) begin
            link.ready_in = k[0];
            mon();
        end
        chk("t3_progress", 32'(pulses >= 20), 32'd1);
        chk("t3_seq_err", 32'(link.seq_err), 32'd0);

        // 4: src_en drops while valid is stalled
        do_reset();
        link.src_en = 1'b1;
        wait_level(4);
        tick();
        link.src_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_valid_held", 32'(dut.r_src_valid), 32'd1);
            chk("t4_data_held", 32'(dut.r_src_data), 32'd4);
        end
        link.ready_in = 1'b1;
        for (int k = 0; k < 12; k++) mon();
        chk("t4_pulses", 32'(pulses), 32'd5);
        chk("t4_level", 32'(link.fifo_level), 32'd0);
        chk("t4_valid_low", 32'(dut.r_src_valid), 32'd0);

        // 5: asynchronous reset mid-stream
        do_reset();
        link.src_en   = 1'b1;
        link.ready_in = 1'b1;
        for (int k = 0; k < 6; k++) mon();
        link.ready_in = 1'b0;
        wait_level(3);
        chk("t5_pre_result", 32'(link.result), 32'd3);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_async_result", 32'(link.result), 32'd0);
        chk("t5_async_cnt", 32'(link.xfer_cnt), 32'd0);
        chk("t5_async_level", 32'(link.fifo_level), 32'd0);
        chk("t5_async_vld", 32'(link.result_vld), 32'd0);
        tick();
        #3;
        rst    = 1'b0;
        exp_w  = 0;
        pulses = 0;
        link.ready_in = 1'b1;
        for (int k = 0; k < 10; k++) mon();
        chk("t5_pulses", 32'(pulses), 32'd8);
        chk("t5_seq_err", 32'(link.seq_err), 32'd0);

        // 6: corrupted head word trips the sticky sequence error
        do_reset();
        link.src_en = 1'b1;
        wait_level(4);
        link.ready_in = 1'b1;
        mon();
        mon();
        chk("t6_pre_err", 32'(link.seq_err), 32'd0);
        force dut.w_fifo_data = 3'd5;
        tick();
        release dut.w_fifo_data;
        chk("t6_forced_result", 32'(link.result), 32'd5);
        chk("t6_seq_err_set", 32'(link.seq_err), 32'd1);
        pulses = pulses + 1;
        exp_w  = 3;
        for (int k = 0; k < 4; k++) begin
            mon();
            chk("t6_seq_err_sticky", 32'(link.seq_err), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_hs_stream_link
`default_nettype wire
